// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the rendering-mode sequencer: mode codes,
// sequencer state encodings and a counter-width helper.
package mode_sequencer_pkg;

    // Well-known rendering mode codes
    localparam int MODE_OFF    = 0;
    localparam int MODE_NORMAL = 1;
    localparam int MODE_VIDEO  = 2;

    // Sequencer state encodings
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_STABLE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_ENTER  = 2'd3;

    // Width needed to hold values 0..n, never less than one bit
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mode_wait_timer.sv
// Loadable saturating down-counter; o_done is high while the count is zero.
module mode_wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; the count holds at zero
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/mode_sequencer.sv
// Rendering-mode sequencer: accepts mode requests, runs each change through
// drain / settle / enter phases gated by the video timing controller, and
// falls back to mode 0 if a gated wait takes too long.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int                        NUM_MODES      = 4,
    parameter int                        MODE_W         = 2,
    parameter int                        RESET_MODE     = 0,
    parameter logic [(1<<MODE_W)-1:0]    TIMING_MASK    = 4'b0110,
    parameter logic [(1<<MODE_W)-1:0]    GATED_MASK     = 4'b0010,
    parameter int                        SETTLE_CYCLES  = 4,
    parameter int                        TIMEOUT_CYCLES = 1024
) (
    input  logic              i_master_clk,
    input  logic              i_reset,
    input  logic [MODE_W-1:0] i_mcu_mode,
    input  logic              i_mcu_mode_valid,
    input  logic              i_video_switch_allowed,
    output logic [MODE_W-1:0] o_status_rendering_mode,
    output logic              o_video_enable,
    output logic              o_busy,
    output logic              o_req_ack,
    output logic              o_req_reject,
    output logic              o_error
);

    localparam int              ST_W        = cnt_width(SETTLE_CYCLES);
    localparam int              TO_W        = cnt_width(TIMEOUT_CYCLES);
    localparam bit              TO_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [MODE_W:0] NUM_MODES_W = (MODE_W+1)'(NUM_MODES);
    localparam logic [MODE_W-1:0] RST_MODE  = (MODE_W)'(RESET_MODE);
    localparam logic [MODE_W-1:0] SAFE_MODE = (MODE_W)'(MODE_OFF);
    localparam logic [ST_W-1:0] SETTLE_LOAD = (ST_W)'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LOAD     = (TO_W)'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t            r_state;
    logic [MODE_W-1:0] r_cur;
    logic [MODE_W-1:0] r_active;
    logic [MODE_W-1:0] r_tgt;
    logic [MODE_W-1:0] r_status;
    logic [MODE_W-1:0] r_pend_mode;
    logic              r_pend_valid;
    logic              r_fallback;
    logic              r_err;
    logic              r_ack;
    logic              r_rej;
    logic              r_busy;
    logic              r_video;

    state_t            w_state_next;
    logic [MODE_W-1:0] w_cur_next;
    logic [MODE_W-1:0] w_active_next;
    logic [MODE_W-1:0] w_tgt_next;
    logic [MODE_W-1:0] w_status_next;
    logic [MODE_W-1:0] w_pend_mode_next;
    logic              w_pend_valid_next;
    logic              w_fallback_next;
    logic              w_err_next;
    logic              w_req_ok;
    logic              w_req_bad;
    logic              w_timeout;
    logic              w_settle_load;
    logic              w_settle_dec;
    logic              w_settle_done;
    logic              w_to_load;
    logic              w_to_dec;
    logic              w_to_done;

    assign w_req_ok  = i_mcu_mode_valid && ({1'b0, i_mcu_mode} < NUM_MODES_W);
    assign w_req_bad = i_mcu_mode_valid && !({1'b0, i_mcu_mode} < NUM_MODES_W);

    mode_wait_timer #(
        .WIDTH (ST_W)
    ) u_settle_timer (
        .i_clk      (i_master_clk),
        .i_srst     (i_reset),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_settle_dec),
        .o_done     (w_settle_done)
    );

    generate
        if (TO_EN) begin : g_timeout
            mode_wait_timer #(
                .WIDTH (TO_W)
            ) u_timeout_timer (
                .i_clk      (i_master_clk),
                .i_srst     (i_reset),
                .i_load     (w_to_load),
                .i_load_val (TO_LOAD),
                .i_dec      (w_to_dec),
                .o_done     (w_to_done)
            );
        end else begin : g_no_timeout
            assign w_to_done = 1'b0;
        end
    endgenerate

    // Next-state logic: request handling, phase sequencing and timeout fallback
    always_comb begin
        w_state_next      = r_state;
        w_cur_next        = r_cur;
        w_active_next     = r_active;
        w_tgt_next        = r_tgt;
        w_status_next     = r_status;
        w_pend_mode_next  = r_pend_mode;
        w_pend_valid_next = r_pend_valid;
        w_fallback_next   = r_fallback;
        w_err_next        = r_err;
        w_timeout         = 1'b0;
        w_settle_load     = 1'b0;
        w_settle_dec      = 1'b0;
        w_to_load         = 1'b0;
        w_to_dec          = 1'b0;

        if (w_req_ok) begin
            w_err_next = 1'b0;
        end

        case (r_state)
            ST_STABLE: begin
                // A fresh request supersedes anything still pending
                if (w_req_ok) begin
                    w_pend_valid_next = 1'b0;
                    if (i_mcu_mode != r_cur) begin
                        w_tgt_next   = i_mcu_mode;
                        w_state_next = ST_DRAIN;
                        w_to_load    = 1'b1;
                    end
                end else if (r_pend_valid) begin
                    w_pend_valid_next = 1'b0;
                    if (r_pend_mode != r_cur) begin
                        w_tgt_next   = r_pend_mode;
                        w_state_next = ST_DRAIN;
                        w_to_load    = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!GATED_MASK[r_cur] || i_video_switch_allowed) begin
                    w_active_next = r_tgt;
                    w_state_next  = ST_SETTLE;
                    w_settle_load = 1'b1;
                end else if (TO_EN && w_to_done) begin
                    w_timeout = 1'b1;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_next = ST_ENTER;
                    w_to_load    = 1'b1;
                end else begin
                    w_settle_dec = 1'b1;
                end
            end
            ST_ENTER: begin
                // The fallback entry into the safe mode is never timed out
                if (!GATED_MASK[r_tgt] || i_video_switch_allowed) begin
                    w_cur_next      = r_tgt;
                    w_status_next   = r_tgt;
                    w_state_next    = ST_STABLE;
                    w_fallback_next = 1'b0;
                end else if (TO_EN && !r_fallback && w_to_done) begin
                    w_timeout = 1'b1;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
            end
        endcase

        if (w_timeout) begin
            w_tgt_next        = SAFE_MODE;
            w_active_next     = SAFE_MODE;
            w_pend_valid_next = 1'b0;
            w_err_next        = 1'b1;
            w_fallback_next   = 1'b1;
            w_state_next      = ST_SETTLE;
            w_settle_load     = 1'b1;
        end

        // Requests arriving mid-transition are parked; the latest one wins,
        // and a request coinciding with a timeout survives the discard
        if ((r_state != ST_STABLE) && w_req_ok) begin
            w_pend_valid_next = 1'b1;
            w_pend_mode_next  = i_mcu_mode;
        end
    end

    // State and registered outputs
    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            r_state      <= ST_STABLE;
            r_cur        <= RST_MODE;
            r_active     <= RST_MODE;
            r_tgt        <= RST_MODE;
            r_status     <= RST_MODE;
            r_pend_mode  <= RST_MODE;
            r_pend_valid <= 1'b0;
            r_fallback   <= 1'b0;
            r_err        <= 1'b0;
            r_ack        <= 1'b0;
            r_rej        <= 1'b0;
            r_busy       <= 1'b0;
            r_video      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cur        <= w_cur_next;
            r_active     <= w_active_next;
            r_tgt        <= w_tgt_next;
            r_status     <= w_status_next;
            r_pend_mode  <= w_pend_mode_next;
            r_pend_valid <= w_pend_valid_next;
            r_fallback   <= w_fallback_next;
            r_err        <= w_err_next;
            r_ack        <= w_req_ok;
            r_rej        <= w_req_bad;
            r_busy       <= (w_state_next != ST_STABLE);
            r_video      <= TIMING_MASK[r_active];
        end
    end

    assign o_status_rendering_mode = r_status;
    assign o_video_enable          = r_video;
    assign o_busy                  = r_busy;
    assign o_req_ack               = r_ack;
    assign o_req_reject            = r_rej;
    assign o_error                 = r_err;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer (NUM_MODES=3, SETTLE=4, TIMEOUT=16).
// Handshake and status-change expectations go through scoreboard queues.
module tb_mode_sequencer;

    localparam int MODE_W    = 2;
    localparam int NUM_MODES = 3;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [MODE_W-1:0] mode = '0;
    logic              mode_valid = 1'b0;
    logic              sw = 1'b0;
    logic [MODE_W-1:0] o_status;
    logic              o_video;
    logic              o_busy;
    logic              o_ack;
    logic              o_rej;
    logic              o_err;

    mode_sequencer #(
        .NUM_MODES      (NUM_MODES),
        .MODE_W         (MODE_W),
        .RESET_MODE     (0),
        .TIMING_MASK    (4'b0110),
        .GATED_MASK     (4'b0010),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_master_clk            (clk),
        .i_reset                 (rst),
        .i_mcu_mode              (mode),
        .i_mcu_mode_valid        (mode_valid),
        .i_video_switch_allowed  (sw),
        .o_status_rendering_mode (o_status),
        .o_video_enable          (o_video),
        .o_busy                  (o_busy),
        .o_req_ack               (o_ack),
        .o_req_reject            (o_rej),
        .o_error                 (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int kind; int cyc;} hs_t;   // kind 1 = ack, 2 = reject
    typedef struct {int mode; int cyc;} st_t;   // cyc < 0 = any cycle
    hs_t hs_q[$];
    st_t st_q[$];
    hs_t mon_hs;
    st_t mon_st;

    int n_checks = 0;
    int n_pass   = 0;
    bit in_reset = 1'b1;
    logic [MODE_W-1:0] prev_status = '0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request strobe; returns at the negedge of the ack cycle
    task automatic request(input int code);
        hs_t e;
        logic [31:0] c;
        c = code;
        mode = c[MODE_W-1:0];
        mode_valid = 1'b1;
        e.kind = (code < NUM_MODES) ? 1 : 2;
        e.cyc  = cyc + 1;
        hs_q.push_back(e);
        @(negedge clk);
        mode_valid = 1'b0;
        $display("req code=%0d ack_cycle=%0d", code, e.cyc);
    endtask

    task automatic push_status(input int m, input int c);
        st_t e;
        e.mode = m;
        e.cyc  = c;
        st_q.push_back(e);
    endtask

    task automatic wait_status_done(input int budget);
        int n;
        n = 0;
        while (st_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if (st_q.size() != 0) begin
            chk("wait_status_budget", st_q.size(), 0);
            st_q.delete();
        end
    endtask

    // Monitor: pops expected handshakes and status changes as they appear
    always @(negedge clk) begin
        if (in_reset) begin
            prev_status = o_status;
        end else begin
            if (o_ack || o_rej) begin
                if (hs_q.size() == 0) begin
                    chk("unexpected_handshake", int'({o_rej, o_ack}), 0);
                end else begin
                    mon_hs = hs_q.pop_front();
                    chk("hs_kind", int'({o_rej, o_ack}), mon_hs.kind);
                    chk("hs_cycle", cyc, mon_hs.cyc);
                end
            end
            if (o_status != prev_status) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_status", int'(o_status), int'(prev_status));
                end else begin
                    mon_st = st_q.pop_front();
                    chk("status_mode", int'(o_status), mon_st.mode);
                    if (mon_st.cyc >= 0) chk("status_cycle", cyc, mon_st.cyc);
                    $display("status -> %0d at cycle %0d", o_status, cyc);
                end
            end
            prev_status = o_status;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        // Reset values
        step(3);
        chk("rst_status", int'(o_status), 0);
        chk("rst_video", int'(o_video), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ack", int'(o_ack), 0);
        chk("rst_reject", int'(o_rej), 0);
        chk("rst_error", int'(o_err), 0);
        rst = 1'b0;
        step(1);
        #1 in_reset = 1'b0;
        step(2);

        // Ungated transition 0 -> 2 with exact latency and busy window
        sw = 1'b1;
        request(2);
        a = cyc;
        push_status(2, a + 2 + SETTLE);
        chk("t2_busy_at_ack", int'(o_busy), 1);
        chk("t2_video_before", int'(o_video), 0);
        step(5);
        chk("t2_busy_last", int'(o_busy), 1);
        step(1);
        chk("t2_busy_done", int'(o_busy), 0);
        chk("t2_status", int'(o_status), 2);
        chk("t2_video", int'(o_video), 1);

        // Back to 0, then 0 -> 1 held in ENTER until switch pulse
        request(0);
        push_status(0, cyc + 2 + SETTLE);
        wait_status_done(50);
        sw = 1'b0;
        request(1);
        a = cyc;
        step(10);
        chk("t3_busy_waiting", int'(o_busy), 1);
        chk("t3_status_waiting", int'(o_status), 0);
        sw = 1'b1;
        push_status(1, a + 11);
        step(1);
        sw = 1'b0;
        chk("t3_status", int'(o_status), 1);

        // Mid-transition requests 2 then 0: both acked, ends in 0
        request(2);
        request(0);
        step(2);
        sw = 1'b1;
        push_status(2, -1);
        push_status(0, -1);
        wait_status_done(100);
        chk("t4_status", int'(o_status), 0);
        chk("t4_busy", int'(o_busy), 0);

        // Illegal code rejected; same-code request acked without transition
        request(3);
        chk("t5_rej_busy", int'(o_busy), 0);
        step(2);
        chk("t5_rej_status", int'(o_status), 0);
        chk("t5_rej_busy2", int'(o_busy), 0);
        request(0);
        chk("t5_same_busy", int'(o_busy), 0);
        step(3);
        chk("t5_same_busy2", int'(o_busy), 0);

        // Timeout in DRAIN from mode 1, fallback to 0, error cleared later
        request(1);
        push_status(1, cyc + 2 + SETTLE);
        wait_status_done(50);
        sw = 1'b0;
        request(0);
        a = cyc;
        step(15);
        chk("t6_err_early", int'(o_err), 0);
        chk("t6_busy_wait", int'(o_busy), 1);
        push_status(0, a + TIMEOUT + SETTLE + 1);
        step(1);
        chk("t6_err_set", int'(o_err), 1);
        wait_status_done(50);
        chk("t6_status", int'(o_status), 0);
        chk("t6_err_sticky", int'(o_err), 1);
        sw = 1'b1;
        request(2);
        chk("t6_err_cleared", int'(o_err), 0);
        push_status(2, cyc + 2 + SETTLE);
        wait_status_done(50);

        // Reset during SETTLE with a pending request
        request(0);
        request(1);
        #1;
        in_reset = 1'b1;
        rst = 1'b1;
        step(1);
        chk("t7_status", int'(o_status), 0);
        chk("t7_busy", int'(o_busy), 0);
        chk("t7_video", int'(o_video), 0);
        chk("t7_ack", int'(o_ack), 0);
        rst = 1'b0;
        step(1);
        #1 in_reset = 1'b0;
        step(12);
        chk("t7_no_pending_busy", int'(o_busy), 0);
        chk("t7_no_pending_status", int'(o_status), 0);

        chk("hs_queue_empty", hs_q.size(), 0);
        chk("status_queue_empty", st_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
